// File: rtl/sprite_writer_if.sv
// Producer stream and sprite-memory write bus for sprite_writer.
// slave is the writer's view; master is the producer/memory side.
interface sprite_writer_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 9
) ();
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic              mem_ack;

   modport slave (
      input  in_data, in_valid, mem_ack,
      output in_ready, mem_address, mem_data, mem_wren
   );

   modport master (
      output in_data, in_valid, mem_ack,
      input  in_ready, mem_address, mem_data, mem_wren
   );
endinterface

// File: rtl/sprite_writer.sv
// Burst writer: copies a counted stream of colour words into consecutive sprite-memory addresses.
// Optional ack watchdog enabled by defining SPRITE_WRITER_ACK_TIMEOUT_EN.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_WAIT_DATA | in_ready high, waiting for a producer word
// S_WRITE     | mem_wren high for one cycle
// S_WAIT_ACK  | waiting for mem_ack (or watchdog expiry)
// S_DONE      | one-cycle done pulse
module sprite_writer #(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 9,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   sprite_writer_if.slave    bus,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DATA,
      S_WRITE,
      S_WAIT_ACK,
      S_DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] count_q;
   logic              ack_timeout;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      busy         = 1'b0;
      done         = 1'b0;
      bus.in_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (length == '0) ? S_DONE : S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            busy         = 1'b1;
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            busy    = 1'b1;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            busy = 1'b1;
            if (bus.mem_ack) begin
               state_d = (count_q == ADDR_W'(1)) ? S_DONE : S_WAIT_DATA;
            end else if (ack_timeout) begin
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory outputs are registered; mem_wren is high only in the cycle spent in S_WRITE.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q          <= '0;
         count_q         <= '0;
         bus.mem_address <= '0;
         bus.mem_data    <= '0;
         bus.mem_wren    <= 1'b0;
      end else begin
         bus.mem_wren <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && (length != '0)) begin
                  addr_q  <= base_addr;
                  count_q <= length;
               end
            end
            S_WAIT_DATA: begin
               if (bus.in_valid) begin
                  bus.mem_address <= addr_q;
                  bus.mem_data    <= bus.in_data;
                  bus.mem_wren    <= 1'b1;
               end
            end
            S_WAIT_ACK: begin
               if (bus.mem_ack) begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  count_q <= count_q - ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SPRITE_WRITER_ACK_TIMEOUT_EN
   localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

   logic [WD_W-1:0] wd_q;
   logic            error_q;

   // Down-counter loaded while writing; terminal count in S_WAIT_ACK means ACK_TIMEOUT cycles elapsed.
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_q    <= '0;
         error_q <= 1'b0;
      end else begin
         if (state_q == S_WRITE) begin
            wd_q <= WD_W'(ACK_TIMEOUT - 1);
         end else if ((state_q == S_WAIT_ACK) && (wd_q != '0)) begin
            wd_q <= wd_q - WD_W'(1);
         end
         if (ack_timeout) begin
            error_q <= 1'b1;
         end
      end
   end

   assign ack_timeout = (state_q == S_WAIT_ACK) && !bus.mem_ack && (wd_q == '0);
   assign error       = error_q;
`else
   // Never true; keeps the watchdog limit referenced when the watchdog is absent.
   assign ack_timeout = (ACK_TIMEOUT < 0);
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_writer.sv
// Self-checking bench for sprite_writer: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_sprite_writer;
   localparam int AW = 14;
   localparam int DW = 9;
   localparam int TO = 8;
   localparam int AMOD = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic          error;

   sprite_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sprite_writer #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: a burst is a list of addresses base+i (mod 2^AW); each word
   // takes a handshake, one write cycle, then an ack wait. m_age counts cycles since handshake.
   bit m_active = 0;
   bit m_done   = 0;
   bit m_err    = 0;
   int m_left   = 0;
   int m_age    = 0;
   int m_addr   = 0;
   int m_maddr  = 0;
   int m_mdata  = 0;
   int q[$];

   always @(posedge clock) begin
      if (reset) begin
         m_active = 0; m_done = 0; m_err = 0; m_left = 0; m_age = 0;
         m_maddr = 0; m_mdata = 0;
         q.delete();
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_active) begin
         if (start) begin
            if (length == '0) begin
               m_done = 1;
            end else begin
               m_active = 1;
               m_left   = int'(length);
               m_addr   = int'(base_addr);
               for (int i = 0; i < int'(length); i++) q.push_back((int'(base_addr) + i) % AMOD);
            end
         end
      end else if (m_age == 0) begin
         if (bus.in_valid) begin
            if (q.size() > 0) chk("model_addr_seq", m_addr, q.pop_front());
            else chk("model_queue_nonempty", q.size(), 1);
            m_maddr = m_addr;
            m_mdata = int'(bus.in_data);
            m_age   = 1;
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (bus.mem_ack) begin
         m_addr = (m_addr + 1) % AMOD;
         m_left--;
         m_age  = 0;
         if (m_left == 0) begin
            m_active = 0;
            m_done   = 1;
         end
      end else begin
`ifdef SPRITE_WRITER_ACK_TIMEOUT_EN
         if (m_age == TO + 1) begin
            m_err = 1; m_active = 0; m_age = 0;
            q.delete();
         end else m_age++;
`else
         m_age++;
`endif
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy", busy, m_active);
         chk("done", done, m_done);
         chk("in_ready", bus.in_ready, m_active && (m_age == 0));
         chk("mem_wren", bus.mem_wren, m_age == 1);
         chk("mem_address", bus.mem_address, m_maddr);
         chk("mem_data", bus.mem_data, m_mdata);
         chk("error", error, m_err);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic kick(input logic [AW-1:0] b, input logic [AW-1:0] l);
      start = 1'b1; base_addr = b; length = l;
      step();
      start = 1'b0;
   endtask

   // Presents one word from S_WAIT_DATA, checks the write, acks in the cycle after mem_wren.
   task automatic do_word(input logic [DW-1:0] d, input logic [AW-1:0] a, input string tag);
      chk({tag, "_ready"}, bus.in_ready, 1);
      bus.in_valid = 1'b1; bus.in_data = d;
      step();
      chk({tag, "_wren"}, bus.mem_wren, 1);
      chk({tag, "_addr"}, bus.mem_address, a);
      chk({tag, "_data"}, bus.mem_data, d);
      step();
      chk({tag, "_wren_low"}, bus.mem_wren, 0);
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_ack = 1'b0;
      step(); step();
      chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_wren", bus.mem_wren, 0);
      chk("rst_addr", bus.mem_address, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      reset = 1'b0;

      kick(14'h0010, 14'd1);
      chk("single_busy", busy, 1);
      do_word(9'h1AB, 14'h0010, "single");
      bus.in_valid = 1'b0;
      chk("single_done", done, 1);
      chk("single_busy_low", busy, 0);
      step();
      chk("single_done_low", done, 0);

      kick(14'h0055, 14'd0);
      chk("zero_done", done, 1);
      chk("zero_wren", bus.mem_wren, 0);
      step();
      chk("zero_done_low", done, 0);

      kick(14'h0100, 14'd4);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            start = 1'b1; base_addr = 14'h2000; length = 14'd7;
         end
         do_word(DW'(i + 1), AW'(14'h0100 + i), "burst");
         start = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("burst_done", done, 1);
      step();

      kick(14'h3FFF, 14'd2);
      do_word(9'h0AA, 14'h3FFF, "wrap0");
      do_word(9'h155, 14'h0000, "wrap1");
      bus.in_valid = 1'b0;
      chk("wrap_done", done, 1);
      step();

      kick(14'h0005, 14'd3);
      bus.in_valid = 1'b1; bus.in_data = 9'h033;
      step();
      chk("rstw_wren", bus.mem_wren, 1);
      reset = 1'b1; bus.in_valid = 1'b0;
      step();
      chk("rstw_wren_low", bus.mem_wren, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_addr", bus.mem_address, 0);
      reset = 1'b0;
      kick(14'h0007, 14'd1);
      chk("post_rst_busy", busy, 1);
      do_word(9'h044, 14'h0007, "post_rst");
      bus.in_valid = 1'b0;
      chk("post_rst_done", done, 1);
      step();

      kick(14'h0020, 14'd1);
      bus.in_valid = 1'b1; bus.in_data = 9'h099;
      step();
      bus.in_valid = 1'b0;
      step();
`ifdef SPRITE_WRITER_ACK_TIMEOUT_EN
      repeat (7) step();
      chk("wd_err_early", error, 0);
      chk("wd_busy_early", busy, 1);
      step();
      chk("wd_err", error, 1);
      chk("wd_busy", busy, 0);
      chk("wd_done", done, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("wd_err_clear", error, 0);
`else
      repeat (20) step();
      chk("stall_busy", busy, 1);
      chk("stall_err", error, 0);
      chk("stall_ready", bus.in_ready, 0);
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      chk("stall_done", done, 1);
      step();
`endif

      for (int c = 0; c < 4000; c++) begin
         reset        = ($urandom_range(0, 299) == 0);
         start        = ($urandom_range(0, 5) == 0);
         length       = AW'($urandom_range(0, 5));
         base_addr    = ($urandom_range(0, 1) == 1) ? AW'(AMOD - 1 - int'($urandom_range(0, 3))) : AW'($urandom);
         bus.in_valid = ($urandom_range(0, 1) == 1);
         bus.in_data  = DW'($urandom);
         bus.mem_ack  = ($urandom_range(0, 1) == 1);
         step();
      end

      reset = 1'b0; start = 1'b0; bus.in_valid = 1'b1; bus.mem_ack = 1'b1;
      repeat (60) step();
      bus.in_valid = 1'b0; bus.mem_ack = 1'b0;
      step();
      chk("drain_idle", busy, 0);
      chk("drain_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
